// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package hazard_pkg;

  // Internal address width; register addresses are zero-extended to this (REG_AW must not exceed it).
  localparam int HZ_AW = 16;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [HZ_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [HZ_AW-1:0] rs;
    logic [HZ_AW-1:0] rt;
    logic [HZ_AW-1:0] wreg;
    logic             regwrite;
    logic             memtoreg;
  } stage_t;

  // Register 0 is hardwired, so it never produces a dependency.
  function automatic logic reg_hit(input logic [HZ_AW-1:0] src,
                                   input logic [HZ_AW-1:0] dst,
                                   input logic             en);
    return en && (src != REG_ZERO) && (src == dst);
  endfunction

endpackage

// File: rtl/hz_shadow_stage.sv
// Generic async-reset pipeline register with hold (freeze) and bubble (clear) controls.
module hz_shadow_stage #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         hold,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // hold wins over bubble so a frozen pipeline never loses its contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (!hold) begin
      q <= bubble ? '0 : d;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline, with shadow E/M/W state.
// Optional stall-cycle counter enabled by defining HZ_PERF_CNT_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] WriteRegD,
  input  logic              RegWriteD,
  input  logic              MemtoRegD,
  input  logic              BranchD,
  input  logic              ExtStall,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushE,
  output logic [CNT_W-1:0]  StallCycles
);

  logic [HZ_AW-1:0] rs_d;
  logic [HZ_AW-1:0] rt_d;
  stage_t           e_d;
  stage_t           e_q;
  logic [HZ_AW+1:0] m_d;
  logic [HZ_AW+1:0] m_q;
  logic [HZ_AW:0]   w_d;
  logic [HZ_AW:0]   w_q;
  logic [HZ_AW-1:0] wreg_m;
  logic             regwrite_m;
  logic             memtoreg_m;
  logic [HZ_AW-1:0] wreg_w;
  logic             regwrite_w;
  logic             ext;
  logic             lwstall;
  logic             branchstall;
  logic             hz;

  assign rs_d = HZ_AW'(RsD);
  assign rt_d = HZ_AW'(RtD);

  always_comb begin
    e_d          = '0;
    e_d.rs       = rs_d;
    e_d.rt       = rt_d;
    e_d.wreg     = HZ_AW'(WriteRegD);
    e_d.regwrite = RegWriteD;
    e_d.memtoreg = MemtoRegD;
  end

  assign m_d = {e_q.wreg, e_q.regwrite, e_q.memtoreg};
  assign {wreg_m, regwrite_m, memtoreg_m} = m_q;
  assign w_d = {wreg_m, regwrite_m};
  assign {wreg_w, regwrite_w} = w_q;

  // The stall input is masked while in reset so every output reads 0 then.
  assign ext = ExtStall & reset_n;

  hz_shadow_stage #(.W($bits(stage_t))) u_stage_e (
    .clk     (clk),
    .reset_n (reset_n),
    .hold    (ext),
    .bubble  (FlushE),
    .d       (e_d),
    .q       (e_q)
  );

  hz_shadow_stage #(.W(HZ_AW + 2)) u_stage_m (
    .clk     (clk),
    .reset_n (reset_n),
    .hold    (ext),
    .bubble  (1'b0),
    .d       (m_d),
    .q       (m_q)
  );

  hz_shadow_stage #(.W(HZ_AW + 1)) u_stage_w (
    .clk     (clk),
    .reset_n (reset_n),
    .hold    (ext),
    .bubble  (1'b0),
    .d       (w_d),
    .q       (w_q)
  );

  assign ForwardAD = reg_hit(rs_d, wreg_m, regwrite_m);
  assign ForwardBD = reg_hit(rt_d, wreg_m, regwrite_m);

  // M result is newer than W, so it takes priority.
  always_comb begin
    ForwardAE = FWD_RF;
    if (reg_hit(e_q.rs, wreg_m, regwrite_m))      ForwardAE = FWD_MEM;
    else if (reg_hit(e_q.rs, wreg_w, regwrite_w)) ForwardAE = FWD_WB;
    ForwardBE = FWD_RF;
    if (reg_hit(e_q.rt, wreg_m, regwrite_m))      ForwardBE = FWD_MEM;
    else if (reg_hit(e_q.rt, wreg_w, regwrite_w)) ForwardBE = FWD_WB;
  end

  assign lwstall = e_q.memtoreg &
                   (reg_hit(rs_d, e_q.wreg, e_q.regwrite) |
                    reg_hit(rt_d, e_q.wreg, e_q.regwrite));

  // Branches resolve in D: wait for any ALU result in E and any load still in M.
  assign branchstall = BranchD &
                       (reg_hit(rs_d, e_q.wreg, e_q.regwrite) |
                        reg_hit(rt_d, e_q.wreg, e_q.regwrite) |
                        reg_hit(rs_d, wreg_m, memtoreg_m)     |
                        reg_hit(rt_d, wreg_m, memtoreg_m));

  assign hz     = lwstall | branchstall;
  assign StallF = hz | ext;
  assign StallD = hz | ext;
  assign FlushE = hz & ~ext;

`ifdef HZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (StallD && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign StallCycles = stall_cnt;
`else
  assign StallCycles = '0;
`endif

endmodule
